// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM + MEM/WB forwarding and load-use bubble; ID_EX_PERF_EN adds stall/flush counters.
// Latency: 1 cycle ID->EX; forwarding and stall_id are combinational in the ID cycle.
// Backpressure: ex_hold freezes the register and raises stall_id; flush overrides both hold and load-use.
module id_ex_stage #(
    parameter int DW  = 16,
    parameter int IRW = 19,
    parameter int AW  = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           id_valid,
    input  logic [IRW-1:0] ir_id,
    input  logic [AW-1:0]  rs1_id,
    input  logic [AW-1:0]  rs2_id,
    input  logic [AW-1:0]  rd_id,
    input  logic [DW-1:0]  rout1_id,
    input  logic [DW-1:0]  rout2_id,
    input  logic           re1_id,
    input  logic           re2_id,
    input  logic           we_id,
    input  logic           mem_read_id,
    input  logic           exm_we,
    input  logic [AW-1:0]  exm_rd,
    input  logic [DW-1:0]  exm_data,
    input  logic           wb_we,
    input  logic [AW-1:0]  wb_rd,
    input  logic [DW-1:0]  wb_data,
    input  logic           ex_hold,
    input  logic           flush,
    output logic           stall_id,
    output logic           ex_valid,
    output logic [IRW-1:0] ir_ex,
    output logic [AW-1:0]  rd_ex,
    output logic [DW-1:0]  op1_ex,
    output logic [DW-1:0]  op2_ex,
    output logic           we_ex,
    output logic           mem_read_ex
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0]    stall_cnt,
    output logic [15:0]    flush_cnt
`endif
);

    logic [DW-1:0] op1_fwd;
    logic [DW-1:0] op2_fwd;
    logic          luh;

    // The newer producer (EX/MEM) shadows the older one (MEM/WB).
    always_comb begin
        op1_fwd = '0;
        if (re1_id) begin
            if (exm_we && exm_rd == rs1_id)
                op1_fwd = exm_data;
            else if (wb_we && wb_rd == rs1_id)
                op1_fwd = wb_data;
            else
                op1_fwd = rout1_id;
        end
    end

    always_comb begin
        op2_fwd = '0;
        if (re2_id) begin
            if (exm_we && exm_rd == rs2_id)
                op2_fwd = exm_data;
            else if (wb_we && wb_rd == rs2_id)
                op2_fwd = wb_data;
            else
                op2_fwd = rout2_id;
        end
    end

    // A load in EX has no data yet for any operand the ID instruction reads.
    assign luh = ex_valid && mem_read_ex && we_ex && id_valid &&
                 ((re1_id && rs1_id == rd_ex) || (re2_id && rs2_id == rd_ex));

    assign stall_id = !flush && (ex_hold || luh);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ir_ex       <= '0;
            rd_ex       <= '0;
            op1_ex      <= '0;
            op2_ex      <= '0;
            we_ex       <= 1'b0;
            mem_read_ex <= 1'b0;
        end else if (flush || (!ex_hold && luh)) begin
            ex_valid    <= 1'b0;
            ir_ex       <= '0;
            rd_ex       <= '0;
            op1_ex      <= '0;
            op2_ex      <= '0;
            we_ex       <= 1'b0;
            mem_read_ex <= 1'b0;
        end else if (!ex_hold) begin
            ex_valid    <= id_valid;
            ir_ex       <= ir_id;
            rd_ex       <= rd_id;
            op1_ex      <= op1_fwd;
            op2_ex      <= op2_fwd;
            we_ex       <= we_id && id_valid;
            mem_read_ex <= mem_read_id && id_valid;
        end
    end

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (luh && !flush && !ex_hold && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Vector table plus load-use / flush / hold / async-reset sequences, checked through an expected-output queue.
module tb_id_ex_stage;

    logic        clk, reset;
    logic        id_valid, re1_id, re2_id, we_id, mem_read_id;
    logic [18:0] ir_id;
    logic [3:0]  rs1_id, rs2_id, rd_id, exm_rd, wb_rd;
    logic [15:0] rout1_id, rout2_id, exm_data, wb_data;
    logic        exm_we, wb_we, ex_hold, flush;
    logic        stall_id, ex_valid, we_ex, mem_read_ex;
    logic [18:0] ir_ex;
    logic [3:0]  rd_ex;
    logic [15:0] op1_ex, op2_ex;
`ifdef ID_EX_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    id_ex_stage #(.DW(16), .IRW(19), .AW(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .ir_id(ir_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .rout1_id(rout1_id), .rout2_id(rout2_id), .re1_id(re1_id), .re2_id(re2_id),
        .we_id(we_id), .mem_read_id(mem_read_id),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_hold(ex_hold), .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ir_ex(ir_ex), .rd_ex(rd_ex),
        .op1_ex(op1_ex), .op2_ex(op2_ex), .we_ex(we_ex), .mem_read_ex(mem_read_ex)
`ifdef ID_EX_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [18:0] ir;
        logic [3:0]  rd;
        logic [15:0] op1;
        logic [15:0] op2;
        logic        we;
        logic        mr;
    } exp_t;

    typedef struct {
        logic        iv, re1, re2;
        logic [3:0]  rs1, rs2, rd;
        logic [15:0] r1, r2;
        logic        we, mr;
        logic        xwe; logic [3:0] xrd; logic [15:0] xd;
        logic        wwe; logic [3:0] wrd; logic [15:0] wd;
        logic        e_v; logic [15:0] e_op1, e_op2; logic e_we, e_mr;
    } vec_t;

    exp_t expq[$];
    exp_t zero_e;
    vec_t vt[9];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t cur();
        return '{ex_valid, ir_ex, rd_ex, op1_ex, op2_ex, we_ex, mem_read_ex};
    endfunction

    function automatic exp_t mk(logic v, logic [18:0] ir, logic [3:0] rd, logic [15:0] o1,
                                logic [15:0] o2, logic w, logic m);
        return '{v, ir, rd, o1, o2, w, m};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one edge and compare the registered outputs with the oldest expectation.
    task automatic step(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk(nm, 64'(cur()), 64'(e));
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no expectation queued, required one", nm);
        end
    endtask

    task automatic set_id(input logic iv, input logic [18:0] ir, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [3:0] d, input logic [15:0] r1, input logic [15:0] r2,
                          input logic e1, input logic e2, input logic w, input logic m);
        id_valid = iv; ir_id = ir; rs1_id = s1; rs2_id = s2; rd_id = d;
        rout1_id = r1; rout2_id = r2; re1_id = e1; re2_id = e2; we_id = w; mem_read_id = m;
    endtask

    task automatic set_fwd(input logic xw, input logic [3:0] xr, input logic [15:0] xd,
                           input logic ww, input logic [3:0] wr, input logic [15:0] wdat);
        exm_we = xw; exm_rd = xr; exm_data = xd; wb_we = ww; wb_rd = wr; wb_data = wdat;
    endtask

    initial begin
        zero_e = '0;
        //        iv re1 re2 rs1 rs2 rd  rout1     rout2     we mr  xwe xrd xd        wwe wrd wd        e_v e_op1     e_op2     e_we e_mr
        vt[0] = '{1, 1,  1,  3,  5,  2,  16'h0003, 16'h0005, 1, 0,  0,  0,  16'h0000, 0,  0,  16'h0000, 1,  16'h0003, 16'h0005, 1,   0};
        vt[1] = '{1, 1,  1,  4,  9,  1,  16'h0444, 16'h1234, 1, 0,  1,  4,  16'h00AA, 1,  4,  16'h00BB, 1,  16'h00AA, 16'h1234, 1,   0};
        vt[2] = '{1, 1,  1,  4,  9,  1,  16'h0444, 16'h1234, 1, 0,  0,  4,  16'h00AA, 1,  4,  16'h00BB, 1,  16'h00BB, 16'h1234, 1,   0};
        vt[3] = '{1, 0,  1,  4,  9,  1,  16'h0000, 16'h1234, 0, 0,  1,  4,  16'h00AA, 1,  4,  16'h00BB, 1,  16'h0000, 16'h1234, 0,   0};
        vt[4] = '{1, 1,  1,  0,  0,  3,  16'h0101, 16'h0202, 1, 0,  1,  0,  16'h0055, 1,  0,  16'h0066, 1,  16'h0055, 16'h0055, 1,   0};
        vt[5] = '{0, 1,  0,  1,  2,  3,  16'h0077, 16'h0000, 1, 1,  0,  0,  16'h0000, 0,  0,  16'h0000, 0,  16'h0077, 16'h0000, 0,   0};
        vt[6] = '{1, 1,  1,  5,  6,  4,  16'h0500, 16'h0600, 1, 0,  1,  7,  16'h7777, 1,  6,  16'h00CC, 1,  16'h0500, 16'h00CC, 1,   0};
        vt[7] = '{1, 1,  1,  2,  6,  4,  16'h0200, 16'h0600, 0, 0,  1,  6,  16'h00EE, 1,  2,  16'h00DD, 1,  16'h00DD, 16'h00EE, 0,   0};
        vt[8] = '{1, 1,  0,  1,  3,  5,  16'h0100, 16'h0000, 1, 0,  1,  3,  16'h3333, 1,  3,  16'h4444, 1,  16'h0100, 16'h0000, 1,   0};

        reset = 1'b1; ex_hold = 1'b0; flush = 1'b0;
        set_id(0, 19'h0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);
        set_fwd(0, 0, 16'h0, 0, 0, 16'h0);
        #1;
        chk("reset_regs", 64'(cur()), 64'(zero_e));
        chk("reset_stall", 64'(stall_id), 64'd0);
`ifdef ID_EX_PERF_EN
        chk("reset_cnts", {32'd0, stall_cnt, flush_cnt}, 64'd0);
`endif
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) begin
            @(negedge clk);
            set_id(vt[i].iv, 19'h10000 + 19'(i), vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].r1, vt[i].r2,
                   vt[i].re1, vt[i].re2, vt[i].we, vt[i].mr);
            set_fwd(vt[i].xwe, vt[i].xrd, vt[i].xd, vt[i].wwe, vt[i].wrd, vt[i].wd);
            expq.push_back(mk(vt[i].e_v, 19'h10000 + 19'(i), vt[i].rd, vt[i].e_op1, vt[i].e_op2,
                              vt[i].e_we, vt[i].e_mr));
            #1 chk($sformatf("vec%0d_stall", i), 64'(stall_id), 64'd0);
            step($sformatf("vec%0d", i));
        end

        // Load-use: load r7 in EX, dependent reads r7 on operand 2.
        @(negedge clk);
        set_fwd(0, 0, 16'h0, 0, 0, 16'h0);
        set_id(1, 19'h20007, 1, 0, 7, 16'h0010, 16'h0, 1, 0, 1, 1);
        expq.push_back(mk(1, 19'h20007, 7, 16'h0010, 16'h0, 1, 1));
        step("lu_load");
        @(negedge clk);
        set_id(1, 19'h30008, 2, 7, 8, 16'h0020, 16'h1111, 1, 1, 1, 0);
        expq.push_back(zero_e);
        #1 chk("lu_stall_on", 64'(stall_id), 64'd1);
        step("lu_bubble");
        @(negedge clk);
        set_fwd(0, 0, 16'h0, 1, 7, 16'h4242);
        expq.push_back(mk(1, 19'h30008, 8, 16'h0020, 16'h4242, 1, 0));
        #1 chk("lu_stall_off", 64'(stall_id), 64'd0);
        step("lu_dep_wbfwd");
`ifdef ID_EX_PERF_EN
        chk("lu_cnts", {32'd0, stall_cnt, flush_cnt}, {32'd0, 16'd1, 16'd0});
`endif

        // Flush coinciding with a load-use hazard.
        @(negedge clk);
        set_fwd(0, 0, 16'h0, 0, 0, 16'h0);
        set_id(1, 19'h20007, 1, 0, 7, 16'h0010, 16'h0, 1, 0, 1, 1);
        expq.push_back(mk(1, 19'h20007, 7, 16'h0010, 16'h0, 1, 1));
        step("fl_load");
        @(negedge clk);
        set_id(1, 19'h30008, 2, 7, 8, 16'h0020, 16'h1111, 1, 1, 1, 0);
        flush = 1'b1;
        expq.push_back(zero_e);
        #1 chk("fl_stall", 64'(stall_id), 64'd0);
        step("fl_kill");
`ifdef ID_EX_PERF_EN
        chk("fl_cnts", {32'd0, stall_cnt, flush_cnt}, {32'd0, 16'd1, 16'd1});
`endif

        // Hold: register frozen for 3 cycles while ID changes.
        @(negedge clk);
        flush = 1'b0;
        set_id(1, 19'h40001, 3, 0, 9, 16'h0300, 16'h0, 1, 0, 1, 0);
        expq.push_back(mk(1, 19'h40001, 9, 16'h0300, 16'h0, 1, 0));
        step("hold_pre");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ex_hold = 1'b1;
            set_id(1, 19'h50000 + 19'(k), 4, 5, 4'(10 + k), 16'h0A00 + 16'(k), 16'h0B00, 1, 1, 0, 0);
            expq.push_back(mk(1, 19'h40001, 9, 16'h0300, 16'h0, 1, 0));
            #1 chk($sformatf("hold%0d_stall", k), 64'(stall_id), 64'd1);
            step($sformatf("hold%0d_frozen", k));
        end
        @(negedge clk);
        ex_hold = 1'b0;
        set_id(1, 19'h60006, 4, 5, 6, 16'h0A0A, 16'h0B0B, 1, 1, 1, 0);
        expq.push_back(mk(1, 19'h60006, 6, 16'h0A0A, 16'h0B0B, 1, 0));
        #1 chk("hold_rel_stall", 64'(stall_id), 64'd0);
        step("hold_release");
        @(negedge clk);
        ex_hold = 1'b1; flush = 1'b1;
        expq.push_back(zero_e);
        #1 chk("holdfl_stall", 64'(stall_id), 64'd0);
        step("holdfl_kill");
        ex_hold = 1'b0; flush = 1'b0;
`ifdef ID_EX_PERF_EN
        chk("holdfl_cnts", {32'd0, stall_cnt, flush_cnt}, {32'd0, 16'd1, 16'd2});
`endif

        // Async reset between edges while a load-use stall is pending.
        @(negedge clk);
        set_id(1, 19'h20007, 1, 0, 7, 16'h0010, 16'h0, 1, 0, 1, 1);
        expq.push_back(mk(1, 19'h20007, 7, 16'h0010, 16'h0, 1, 1));
        step("rst_load");
        @(negedge clk);
        set_id(1, 19'h30008, 2, 7, 8, 16'h0020, 16'h1111, 1, 1, 1, 0);
        #1 chk("rst_pre_stall", 64'(stall_id), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_regs", 64'(cur()), 64'(zero_e));
        chk("rst_async_stall", 64'(stall_id), 64'd0);
`ifdef ID_EX_PERF_EN
        chk("rst_async_cnts", {32'd0, stall_cnt, flush_cnt}, 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
